// File: rtl/video_pkg.sv
// Shared timing defaults, coordinate widths and small helpers for the raster
// timing generator and its scan interface.
package video_pkg;

   localparam int unsigned DEF_H_ACTIVE = 320;
   localparam int unsigned DEF_H_FP     = 8;
   localparam int unsigned DEF_H_SYNC   = 48;
   localparam int unsigned DEF_H_BP     = 24;
   localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int unsigned DEF_V_ACTIVE = 240;
   localparam int unsigned DEF_V_FP     = 3;
   localparam int unsigned DEF_V_SYNC   = 4;
   localparam int unsigned DEF_V_BP     = 15;
   localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam bit          DEF_SYNC_ACTIVE_LOW = 1'b1;
   localparam int unsigned DEF_PIPE_DELAY      = 2;

   localparam int unsigned X_W     = 9;
   localparam int unsigned Y_W     = 8;
   localparam int unsigned H_CNT_W = 10;
   localparam int unsigned V_CNT_W = 9;

   localparam int unsigned MAX_H_ACTIVE = 511;
   localparam int unsigned MAX_V_ACTIVE = 256;

   typedef logic [X_W-1:0]     xCoord_t;
   typedef logic [Y_W-1:0]     yCoord_t;
   typedef logic [H_CNT_W-1:0] hCount_t;
   typedef logic [V_CNT_W-1:0] vCount_t;

   // Timing bits that travel together through the reader-latency pipeline.
   typedef struct packed {
      logic hSync;
      logic vSync;
      logic visible;
   } rawTiming_t;

   localparam int unsigned RAW_W = $bits(rawTiming_t);

   // Maps a logical "sync asserted" flag onto the monitor-facing pin level.
   function automatic logic syncLevel(input logic asserted, input bit activeLow);
      return activeLow ? ~asserted : asserted;
   endfunction

endpackage

// File: rtl/video_timing_if.sv
// Scan interface between the timing generator (master) and the video RAM
// reader (slave): coordinates out, pixel data and its qualifier back.
interface video_timing_if;
   import video_pkg::*;

   xCoord_t x;
   yCoord_t y;
   logic    visible;
   logic    pixel;
   logic    valid;

   modport master (
      output x,
      output y,
      output visible,
      input  pixel,
      input  valid
   );

   modport slave (
      input  x,
      input  y,
      input  visible,
      output pixel,
      output valid
   );

endinterface

// File: rtl/video_delay.sv
// Fixed-depth shift register used to match timing signals to the reader latency.
// Every stage clears on reset so a mid-frame reset flushes stale pulses.
module video_delay #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic             vClk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH < 1) begin : gBadDepth
      $error("video_delay: DEPTH must be at least 1");
   end

   logic [WIDTH-1:0] stage [DEPTH];

   // NOTE: this array is reset element by element; it is small, and leaving it
   // unreset would let pre-reset timing leak out after release.
   always_ff @(posedge vClk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= din;
         for (int i = 1; i < int'(DEPTH); i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_timing.sv
// Raster timing generator and monochrome output stage for the video RAM reader.
// Optional frame-start interrupt output enabled by defining VIDEO_FRAME_IRQ_EN.
module video_timing
   import video_pkg::*;
#(
   parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
   parameter int unsigned H_FP            = DEF_H_FP,
   parameter int unsigned H_SYNC          = DEF_H_SYNC,
   parameter int unsigned H_BP            = DEF_H_BP,
   parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
   parameter int unsigned V_FP            = DEF_V_FP,
   parameter int unsigned V_SYNC          = DEF_V_SYNC,
   parameter int unsigned V_BP            = DEF_V_BP,
   parameter bit          SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW,
   parameter int unsigned PIPE_DELAY      = DEF_PIPE_DELAY
) (
   input  logic           vClk,
   input  logic           reset,
   video_timing_if.master scan,
   output logic           hSync,
   output logic           vSync,
   output logic           de,
   output logic           video,
   output logic           syncErr
`ifdef VIDEO_FRAME_IRQ_EN
   ,
   output logic           frameIrq
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_ACTIVE > MAX_H_ACTIVE || V_ACTIVE > MAX_V_ACTIVE) begin : gBadActive
      $error("video_timing: active area exceeds coordinate width");
   end
   if (H_TOTAL > (1 << H_CNT_W) || V_TOTAL > (1 << V_CNT_W)) begin : gBadTotal
      $error("video_timing: line or frame total exceeds counter width");
   end
   if (H_ACTIVE < 1 || V_ACTIVE < 1 || PIPE_DELAY < 1) begin : gBadMin
      $error("video_timing: active area and PIPE_DELAY must be non-zero");
   end

   localparam hCount_t H_LAST     = hCount_t'(H_TOTAL - 1);
   localparam hCount_t H_ACT_C    = hCount_t'(H_ACTIVE);
   localparam hCount_t H_SYNC_BEG = hCount_t'(H_ACTIVE + H_FP);
   localparam hCount_t H_SYNC_END = hCount_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam vCount_t V_LAST     = vCount_t'(V_TOTAL - 1);
   localparam vCount_t V_ACT_C    = vCount_t'(V_ACTIVE);
   localparam vCount_t V_SYNC_BEG = vCount_t'(V_ACTIVE + V_FP);
   localparam vCount_t V_SYNC_END = vCount_t'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic SYNC_IDLE = syncLevel(1'b0, SYNC_ACTIVE_LOW);

   // syncErr stays disarmed until the reader pipeline has filled after reset.
   localparam int unsigned ARM_W = $clog2(PIPE_DELAY + 2);
   typedef logic [ARM_W-1:0] arm_t;
   localparam arm_t ARM_DONE = arm_t'(PIPE_DELAY + 1);

   hCount_t              hCount;
   vCount_t              vCount;
   logic                 hActive;
   logic                 vActive;
   rawTiming_t           rawNow;
   rawTiming_t           rawQ;
   rawTiming_t           rawDly;
   logic [RAW_W-1:0]     rawDlyBits;
   arm_t                 armCnt;
   logic                 armed;

   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge vClk or posedge reset) begin
      if (reset) begin
         hCount <= '0;
         vCount <= '0;
      end else if (hCount == H_LAST) begin
         hCount <= '0;
         vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
      end else begin
         hCount <= hCount + 1'b1;
      end
   end

   assign hActive = hCount < H_ACT_C;
   assign vActive = vCount < V_ACT_C;

   assign rawNow = '{
      hSync:   (hCount >= H_SYNC_BEG) && (hCount < H_SYNC_END),
      vSync:   (vCount >= V_SYNC_BEG) && (vCount < V_SYNC_END),
      visible: hActive && vActive
   };

   // Scan coordinates and raw sync are registered together so that sync
   // keeps its porch spacing relative to the visible window downstream.
   always_ff @(posedge vClk or posedge reset) begin
      if (reset) begin
         scan.x <= '0;
         scan.y <= '0;
         rawQ   <= '0;
      end else begin
         scan.x <= rawNow.visible ? hCount[X_W-1:0] : '0;
         scan.y <= vActive ? vCount[Y_W-1:0] : '0;
         rawQ   <= rawNow;
      end
   end

   assign scan.visible = rawQ.visible;

   video_delay #(
      .WIDTH (RAW_W),
      .DEPTH (PIPE_DELAY)
   ) uDelay (
      .vClk  (vClk),
      .reset (reset),
      .din   (rawQ),
      .dout  (rawDlyBits)
   );

   assign rawDly = rawTiming_t'(rawDlyBits);

   always_ff @(posedge vClk or posedge reset) begin
      if (reset) begin
         hSync <= SYNC_IDLE;
         vSync <= SYNC_IDLE;
         de    <= 1'b0;
         video <= 1'b0;
      end else begin
         hSync <= syncLevel(rawDly.hSync, SYNC_ACTIVE_LOW);
         vSync <= syncLevel(rawDly.vSync, SYNC_ACTIVE_LOW);
         de    <= rawDly.visible;
         video <= rawDly.visible & scan.valid & scan.pixel;
      end
   end

   assign armed = armCnt == ARM_DONE;

   always_ff @(posedge vClk or posedge reset) begin
      if (reset) begin
         armCnt  <= '0;
         syncErr <= 1'b0;
      end else begin
         if (!armed) begin
            armCnt <= armCnt + 1'b1;
         end
         if (armed && (scan.valid != rawDly.visible)) begin
            syncErr <= 1'b1;
         end
      end
   end

`ifdef VIDEO_FRAME_IRQ_EN
   localparam vCount_t V_IRQ_PREV = vCount_t'(V_ACTIVE - 1);

   // Fires as the counters step onto (0, V_ACTIVE): the start of vertical blank.
   always_ff @(posedge vClk or posedge reset) begin
      if (reset) begin
         frameIrq <= 1'b0;
      end else begin
         frameIrq <= (hCount == H_LAST) && (vCount == V_IRQ_PREV);
      end
   end
`endif

endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench for video_timing on a shrunken 28x12 raster with a stub
// reader; frameIrq is checked when VIDEO_FRAME_IRQ_EN is defined.
module tb_video_timing;
   import video_pkg::*;

   localparam int HA = 16, HFP = 3, HS = 5, HBP = 4, HT = HA + HFP + HS + HBP;
   localparam int VA = 6,  VFP = 2, VS = 3, VBP = 1, VT = VA + VFP + VS + VBP;
   localparam int FT = HT * VT;
`ifdef VIDEO_FRAME_IRQ_EN
   localparam int IRQ_ON = 1;
`else
   localparam int IRQ_ON = 0;
`endif

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic       visible;
      logic       hSync;
      logic       vSync;
      logic       de;
      logic       video;
      logic       syncErr;
      logic       frameIrq;
   } obs_t;

   typedef struct {
      int   phase;
      int   n;
      obs_t exp;
   } entry_t;

   typedef struct {
      int phase;
      int de;
      int video;
      int vsFall;
      int irq;
      int firstDe;
      int firstHs;
   } stat_t;

   logic vClk = 1'b0;
   logic reset = 1'b1;
   logic hSync, vSync, de, video, syncErr;
`ifdef VIDEO_FRAME_IRQ_EN
   logic frameIrq;
`endif

   video_timing_if scanIf ();

   video_timing #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_ACTIVE_LOW(1'b1), .PIPE_DELAY(2)
   ) dut (
      .vClk    (vClk),
      .reset   (reset),
      .scan    (scanIf),
      .hSync   (hSync),
      .vSync   (vSync),
      .de      (de),
      .video   (video),
      .syncErr (syncErr)
`ifdef VIDEO_FRAME_IRQ_EN
      ,
      .frameIrq(frameIrq)
`endif
   );

   always #5 vClk = ~vClk;

   // Reader stub: returns visible/pixel after rdDelay clocks.
   int       pixMode = 0;
   int       rdDelay = 2;
   logic     pixNow;
   logic [3:0] visSr, pixSr;

   always_comb begin
      pixNow = 1'b0;
      case (pixMode)
         0: pixNow = scanIf.x[0];
         1: pixNow = (scanIf.x == 9'd5) && (scanIf.y == 8'd3);
         default: pixNow = 1'b0;
      endcase
   end

   always @(posedge vClk or posedge reset) begin
      if (reset) begin
         visSr <= '0;
         pixSr <= '0;
      end else begin
         visSr <= {visSr[2:0], scanIf.visible};
         pixSr <= {pixSr[2:0], pixNow};
      end
   end

   assign scanIf.valid = visSr[rdDelay-1];
   assign scanIf.pixel = pixSr[rdDelay-1];

   // Expected observation n clocks after reset release; coordinates lag the
   // counter by one clock, monitor outputs by four.
   function automatic obs_t model(input int n, input bit inRst, input int mode, input bit errOn);
      obs_t e;
      int q, h, v;
      e = '0;
      e.hSync = 1'b1;
      e.vSync = 1'b1;
      if (inRst) return e;
      if (n >= 1) begin
         q = n - 1;
         h = q % HT;
         v = (q / HT) % VT;
         e.visible = (h < HA) && (v < VA);
         e.x = e.visible ? 9'(h) : 9'd0;
         e.y = (v < VA) ? 8'(v) : 8'd0;
      end
      if (n >= 4) begin
         q = n - 4;
         h = q % HT;
         v = (q / HT) % VT;
         e.de    = (h < HA) && (v < VA);
         e.hSync = !((h >= HA + HFP) && (h < HA + HFP + HS));
         e.vSync = !((v >= VA + VFP) && (v < VA + VFP + VS));
         case (mode)
            0:       e.video = e.de && (h % 2 == 1);
            1:       e.video = e.de && (h == 5) && (v == 3);
            default: e.video = 1'b0;
         endcase
         e.syncErr = errOn;
      end
      e.frameIrq = (IRQ_ON != 0) && (n % FT == VA * HT);
      return e;
   endfunction

   function automatic obs_t sampleObs();
      obs_t o;
      o.x       = scanIf.x;
      o.y       = scanIf.y;
      o.visible = scanIf.visible;
      o.hSync   = hSync;
      o.vSync   = vSync;
      o.de      = de;
      o.video   = video;
      o.syncErr = syncErr;
`ifdef VIDEO_FRAME_IRQ_EN
      o.frameIrq = frameIrq;
`else
      o.frameIrq = 1'b0;
`endif
      return o;
   endfunction

   entry_t expQ[$];
   stat_t  statQ[$];
   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected observation per clock, plus per-phase statistics.
   int   deCnt[8]   = '{default: 0};
   int   vidCnt[8]  = '{default: 0};
   int   vsFall[8]  = '{default: 0};
   int   irqCnt[8]  = '{default: 0};
   int   firstDe[8] = '{default: -1};
   int   firstHs[8] = '{default: -1};
   logic prevVs = 1'b1;

   always @(negedge vClk) begin : monitor
      entry_t e;
      stat_t  s;
      obs_t   act;
      if (expQ.size() != 0) begin
         e   = expQ.pop_front();
         act = sampleObs();
         check($sformatf("obs phase%0d n%0d", e.phase, e.n), 64'(act), 64'(e.exp));
         if (act.de === 1'b1) begin
            deCnt[e.phase]++;
            if (firstDe[e.phase] < 0) firstDe[e.phase] = e.n;
         end
         if (act.hSync === 1'b0 && firstHs[e.phase] < 0) firstHs[e.phase] = e.n;
         if (act.video === 1'b1) vidCnt[e.phase]++;
         if (act.frameIrq === 1'b1) irqCnt[e.phase]++;
         if (prevVs === 1'b1 && act.vSync === 1'b0) vsFall[e.phase]++;
         prevVs = act.vSync;
      end
      if (statQ.size() != 0) begin
         s = statQ.pop_front();
         check($sformatf("deCount phase%0d", s.phase),    64'(deCnt[s.phase]),   64'(s.de));
         check($sformatf("videoCount phase%0d", s.phase), 64'(vidCnt[s.phase]),  64'(s.video));
         check($sformatf("vsFall phase%0d", s.phase),     64'(vsFall[s.phase]),  64'(s.vsFall));
         check($sformatf("irqCount phase%0d", s.phase),   64'(irqCnt[s.phase]),  64'(s.irq));
         check($sformatf("firstDe phase%0d", s.phase),    64'(firstDe[s.phase]), 64'(s.firstDe));
         check($sformatf("firstHs phase%0d", s.phase),    64'(firstHs[s.phase]), 64'(s.firstHs));
      end
   end

   // Stimulus
   int phaseId = 0;
   int n = 0;
   bit errMode = 1'b0;

   task automatic step(input logic r);
      entry_t e;
      @(posedge vClk);
      if (!reset) n++;
      #1;
      reset = r;
      if (r) n = 0;
      e.phase = phaseId;
      e.n     = n;
      e.exp   = model(n, r, pixMode, errMode && (n >= 4));
      expQ.push_back(e);
   endtask

   task automatic pushStat(input int de_, input int vid, input int vsf, input int irq,
                           input int fde, input int fhs);
      stat_t s;
      s.phase = phaseId; s.de = de_; s.video = vid; s.vsFall = vsf;
      s.irq = irq; s.firstDe = fde; s.firstHs = fhs;
      statQ.push_back(s);
      @(negedge vClk);
      #1;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      // Phase 0: held in reset, everything at reset level.
      phaseId = 0;
      for (int i = 0; i < 3; i++) step(1'b1);
      pushStat(0, 0, 0, 0, -1, -1);

      // Phase 1: two frames, pixel = x[0]. de 2*16*6, video 2*8*6,
      // first de at n=4, first hSync low at n=4+19.
      phaseId = 1;
      for (int i = 0; i < 673; i++) step(1'b0);
      pushStat(192, 96, 2, 2 * IRQ_ON, 4, 23);

      // Phase 2: single lit pixel (5,3) -> video at n=4+3*28+5=93; stop at
      // counter position h=11 of line 4 (n=123 reset mid-line below).
      phaseId = 2;
      step(1'b1);
      pixMode = 1;
      step(1'b0);
      for (int i = 0; i < 122; i++) step(1'b0);
      pushStat(71, 1, 0, 0, 4, 23);

      // Phase 3: reset asserted mid-line for two clocks.
      phaseId = 3;
      for (int i = 0; i < 2; i++) step(1'b1);
      pushStat(0, 0, 0, 0, -1, -1);

      // Phase 4: fresh frame from (0,0), no stray de, one irq at n=168.
      phaseId = 4;
      for (int i = 0; i < 340; i++) step(1'b0);
      pushStat(96, 1, 1, IRQ_ON, 4, 23);

      // Phase 5: reset while switching the reader stub to 3-clock latency.
      phaseId = 5;
      step(1'b1);
      rdDelay = 3;
      pixMode = 2;
      errMode = 1'b1;
      step(1'b1);
      pushStat(0, 0, 0, 0, -1, -1);

      // Phase 6: syncErr sets at n=4 and stays set.
      phaseId = 6;
      for (int i = 0; i < 81; i++) step(1'b0);
      pushStat(48, 0, 0, 0, 4, 23);

      // Phase 7: reset clears the sticky error.
      phaseId = 7;
      errMode = 1'b0;
      for (int i = 0; i < 2; i++) step(1'b1);
      pushStat(0, 0, 0, 0, -1, -1);

      repeat (2) @(negedge vClk);
      check("scoreboard drained", 64'(expQ.size() + statQ.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
